// File: rtl/c_join_4ph.sv
// c_join_4ph: clocked N-way four-phase join (C-element successor) with
// bundled-data capture, sticky protocol-violation flag and a wrapping
// completed-handshake counter. All outputs come from flops or are decoded
// from the state register; no input reaches an output combinationally.
module c_join_4ph #(
   parameter int NIN = 2,
   parameter int DW  = 8,
   parameter int CW  = 16
) (
   input  logic                clk,
   input  logic                rst_async_n,
   input  logic [NIN-1:0]      in_req,
   input  logic [NIN*DW-1:0]   in_data,
   output logic [NIN-1:0]      in_ack,
   output logic                out_req,
   output logic [NIN*DW-1:0]   out_data,
   input  logic                out_ack,
   input  logic                err_clr,
   output logic                err,
   output logic [CW-1:0]       hs_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      RTZ  = 2'd3
   } state_t;

   state_t              state;
   state_t              state_nxt;
   logic [1:0]          rst_sync;
   logic                rst_n;
   logic [NIN-1:0]      req_prev;
   logic [NIN*DW-1:0]   data_q;
   logic                err_q;
   logic [CW-1:0]       cnt_q;
   logic                all_hi;
   logic                all_lo;
   logic                any_fell;
   logic                any_rose;
   logic                viol;
   logic                capture;
   logic                count_en;

   // Reset synchroniser: assertion propagates immediately, release after two edges
   always_ff @(posedge clk or negedge rst_async_n) begin
      if (!rst_async_n) rst_sync <= '0;
      else              rst_sync <= {rst_sync[0], 1'b1};
   end

   assign rst_n = rst_sync[1];

   assign all_hi   = &in_req;
   assign all_lo   = ~|in_req;
   assign any_fell = |(req_prev & ~in_req);
   assign any_rose = |(~req_prev & in_req);

   // Next-state, protocol checks and datapath enables for the current phase
   always_comb begin
      state_nxt = state;
      viol      = 1'b0;
      capture   = 1'b0;
      count_en  = 1'b0;
      case (state)
         IDLE: begin
            viol = any_fell | out_ack;
            if (all_hi) begin
               state_nxt = REQ;
               capture   = 1'b1;
            end
         end
         REQ: begin
            viol = ~all_hi;
            if (out_ack) state_nxt = HOLD;
         end
         HOLD: begin
            viol = ~out_ack;
            if (all_lo) state_nxt = RTZ;
         end
         RTZ: begin
            viol = any_rose;
            if (!out_ack) begin
               state_nxt = IDLE;
               count_en  = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State, sampled requests, captured data, sticky error and counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         req_prev <= '0;
         data_q   <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state    <= state_nxt;
         req_prev <= in_req;
         if (capture)       data_q <= in_data;
         // a new violation takes priority over a clear in the same cycle
         if (viol)          err_q  <= 1'b1;
         else if (err_clr)  err_q  <= 1'b0;
         if (count_en)      cnt_q  <= cnt_q + CW'(1);
      end
   end

   assign out_req  = (state == REQ) || (state == HOLD);
   assign in_ack   = {NIN{(state == HOLD) || (state == RTZ)}};
   assign out_data = data_q;
   assign err      = err_q;
   assign hs_count = cnt_q;

endmodule

// File: tb/tb_c_join_4ph.sv
// Bench for c_join_4ph: a two-channel instance (CW=4 so wrap is reachable)
// checked against a phase-counting reference model, plus a one-channel
// instance exercised as a plain four-phase register stage.
module tb_c_join_4ph;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  in_req;
   logic [15:0] in_data;
   logic [1:0]  in_ack;
   logic        out_req;
   logic [15:0] out_data;
   logic        out_ack;
   logic        err_clr;
   logic        err;
   logic [3:0]  hs_count;

   logic [0:0]  r1_req;
   logic [7:0]  r1_data;
   logic [0:0]  r1_in_ack;
   logic        r1_out_req;
   logic [7:0]  r1_out_data;
   logic        r1_out_ack;
   logic        r1_err_clr;
   logic        r1_err;
   logic [3:0]  r1_hs_count;

   int n_tests = 0;
   int n_fail  = 0;

   // reference model: phase 0..3 = waiting-join, requesting, held, returning
   int          m_phase;
   logic [1:0]  m_prev;
   logic [15:0] m_data;
   logic        m_err;
   int          m_cnt;

   c_join_4ph #(.NIN(2), .DW(8), .CW(4)) dut (
      .clk(clk), .rst_async_n(rst_n), .in_req(in_req), .in_data(in_data),
      .in_ack(in_ack), .out_req(out_req), .out_data(out_data), .out_ack(out_ack),
      .err_clr(err_clr), .err(err), .hs_count(hs_count)
   );

   c_join_4ph #(.NIN(1), .DW(8), .CW(4)) dut1 (
      .clk(clk), .rst_async_n(rst_n), .in_req(r1_req), .in_data(r1_data),
      .in_ack(r1_in_ack), .out_req(r1_out_req), .out_data(r1_out_data), .out_ack(r1_out_ack),
      .err_clr(r1_err_clr), .err(r1_err), .hs_count(r1_hs_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin : ref_model
      logic all1, none, rose, fell, viol, adv;
      if (!rst_n) begin
         m_phase <= 0;
         m_prev  <= 2'b00;
         m_data  <= 16'h0000;
         m_err   <= 1'b0;
         m_cnt   <= 0;
      end else begin
         all1 = (in_req == 2'b11);
         none = (in_req == 2'b00);
         rose = ((~m_prev & in_req) != 2'b00);
         fell = ((m_prev & ~in_req) != 2'b00);
         if (m_phase == 0) begin
            viol = fell || out_ack;  adv = all1;
         end else if (m_phase == 1) begin
            viol = !all1;            adv = out_ack;
         end else if (m_phase == 2) begin
            viol = !out_ack;         adv = none;
         end else begin
            viol = rose;             adv = !out_ack;
         end
         if (m_phase == 0 && all1) m_data <= in_data;
         if (m_phase == 3 && adv)  m_cnt  <= (m_cnt + 1) % 16;
         m_phase <= adv ? (m_phase + 1) % 4 : m_phase;
         m_err   <= viol ? 1'b1 : (err_clr ? 1'b0 : m_err);
         m_prev  <= in_req;
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      in_req = 2'b00; in_data = 16'h0000; out_ack = 1'b0; err_clr = 1'b0;
      r1_req = 1'b0;  r1_data = 8'h00;    r1_out_ack = 1'b0; r1_err_clr = 1'b0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic do_handshake(input logic [15:0] d);
      in_req = 2'b11; in_data = d; tick();
      out_ack = 1'b1; tick();
      in_req = 2'b00; tick();
      out_ack = 1'b0; tick();
   endtask

   task automatic test_reset();
      @(negedge clk);
      idle_inputs();
      rst_n = 1'b0;
      #2;
      n_tests++;
      if ({out_req, in_ack, out_data, err, hs_count} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_state: req=%b ack=%b data=%h err=%b cnt=%0d, required all zero",
                  out_req, in_ack, out_data, err, hs_count);
      end
      n_tests++;
      if ({r1_out_req, r1_in_ack, r1_out_data, r1_err, r1_hs_count} !== 15'h0) begin
         n_fail++;
         $display("FAIL reset_state_nin1: req=%b ack=%b data=%h err=%b cnt=%0d, required all zero",
                  r1_out_req, r1_in_ack, r1_out_data, r1_err, r1_hs_count);
      end
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_partial_join();
      in_req = 2'b01;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_tests++;
         if (out_req !== 1'b0 || in_ack !== 2'b00) begin
            n_fail++;
            $display("FAIL partial_hold[%0d]: out_req=%b in_ack=%b, required 0/00", i, out_req, in_ack);
         end
      end
      in_req = 2'b11; in_data = 16'hA53C;
      tick();
      n_tests++;
      if (out_req !== 1'b1 || out_data !== 16'hA53C || in_ack !== 2'b00 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL join_rise: out_req=%b out_data=%h in_ack=%b err=%b, required 1/a53c/00/0",
                  out_req, out_data, in_ack, err);
      end
   endtask

   task automatic test_handshake();
      out_ack = 1'b1; tick();
      n_tests++;
      if (in_ack !== 2'b11 || out_req !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_ack: in_ack=%b out_req=%b, required 11/1", in_ack, out_req);
      end
      in_req = 2'b00; tick();
      n_tests++;
      if (out_req !== 1'b0 || in_ack !== 2'b11) begin
         n_fail++;
         $display("FAIL rtz_req: out_req=%b in_ack=%b, required 0/11", out_req, in_ack);
      end
      out_ack = 1'b0; tick();
      n_tests++;
      if (hs_count !== 4'd1 || err !== 1'b0 || in_ack !== 2'b00 || out_req !== 1'b0) begin
         n_fail++;
         $display("FAIL handshake_done: cnt=%0d err=%b in_ack=%b out_req=%b, required 1/0/00/0",
                  hs_count, err, in_ack, out_req);
      end
   endtask

   task automatic test_violation();
      in_req = 2'b11; in_data = 16'h1111; tick();
      in_req = 2'b01; tick();
      n_tests++;
      if (err !== 1'b1 || out_req !== 1'b1) begin
         n_fail++;
         $display("FAIL req_drop_err: err=%b out_req=%b, required 1/1", err, out_req);
      end
      in_req = 2'b11; err_clr = 1'b1; tick();
      n_tests++;
      if (err !== 1'b0) begin
         n_fail++;
         $display("FAIL err_clear: err=%b, required 0", err);
      end
      err_clr = 1'b0;
      out_ack = 1'b1; tick();
      in_req = 2'b00; tick();
      out_ack = 1'b0; tick();
      n_tests++;
      if (hs_count !== 4'd2 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL clean_after_clear: cnt=%0d err=%b, required 2/0", hs_count, err);
      end
      out_ack = 1'b1; tick();
      n_tests++;
      if (err !== 1'b1 || out_req !== 1'b0) begin
         n_fail++;
         $display("FAIL idle_ack_err: err=%b out_req=%b, required 1/0", err, out_req);
      end
      err_clr = 1'b1; tick();
      n_tests++;
      if (err !== 1'b1) begin
         n_fail++;
         $display("FAIL set_beats_clear: err=%b, required 1", err);
      end
      out_ack = 1'b0; tick();
      n_tests++;
      if (err !== 1'b0 || err !== m_err) begin
         n_fail++;
         $display("FAIL clear_after_ack_drop: err=%b model=%b, required 0", err, m_err);
      end
      err_clr = 1'b0;
   endtask

   task automatic test_data_stability();
      in_req = 2'b11; in_data = 16'hA53C; tick();
      in_data = 16'hFFFF; tick();
      n_tests++;
      if (out_data !== 16'hA53C) begin
         n_fail++;
         $display("FAIL data_stable_req: out_data=%h, required a53c", out_data);
      end
      out_ack = 1'b1; tick();
      n_tests++;
      if (out_data !== 16'hA53C || in_ack !== 2'b11) begin
         n_fail++;
         $display("FAIL data_stable_hold: out_data=%h in_ack=%b, required a53c/11", out_data, in_ack);
      end
      in_req = 2'b00; tick();
      out_ack = 1'b0; tick();
      n_tests++;
      if (out_data !== 16'hA53C || hs_count !== 4'd3) begin
         n_fail++;
         $display("FAIL data_stable_idle: out_data=%h cnt=%0d, required a53c/3", out_data, hs_count);
      end
      in_req = 2'b11; tick();
      n_tests++;
      if (out_data !== 16'hFFFF || out_data !== m_data) begin
         n_fail++;
         $display("FAIL data_recapture: out_data=%h model=%h, required ffff", out_data, m_data);
      end
      out_ack = 1'b1; tick();
      in_req = 2'b00; tick();
      out_ack = 1'b0; tick();
   endtask

   task automatic test_wrap();
      apply_reset();
      for (int i = 0; i < 16; i++) do_handshake(16'(i));
      n_tests++;
      if (hs_count !== 4'd0) begin
         n_fail++;
         $display("FAIL wrap_16: hs_count=%0d, required 0", hs_count);
      end
      do_handshake(16'h0BAD);
      n_tests++;
      if (hs_count !== 4'd1 || err !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_17: hs_count=%0d err=%b, required 1/0", hs_count, err);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         in_req  = 2'($urandom_range(0, 3));
         in_data = 16'($urandom);
         out_ack = 1'($urandom_range(0, 1));
         err_clr = ($urandom_range(0, 3) == 0);
         tick();
         n_tests++;
         if (out_req !== (m_phase == 1 || m_phase == 2) ||
             in_ack !== ((m_phase >= 2) ? 2'b11 : 2'b00) ||
             out_data !== m_data || err !== m_err || hs_count !== 4'(m_cnt)) begin
            n_fail++;
            $display("FAIL random[%0d]: req=%b ack=%b data=%h err=%b cnt=%0d, model phase=%0d data=%h err=%b cnt=%0d",
                     i, out_req, in_ack, out_data, err, hs_count, m_phase, m_data, m_err, m_cnt);
         end
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      apply_reset();
      do_handshake(16'h7777);
      out_ack = 1'b1; tick();
      out_ack = 1'b0;
      in_req = 2'b11; in_data = 16'h1234; tick();
      out_ack = 1'b1; tick();
      n_tests++;
      if (in_ack !== 2'b11 || err !== 1'b1 || hs_count !== 4'd1 || out_data !== 16'h1234) begin
         n_fail++;
         $display("FAIL pre_reset_hold: in_ack=%b err=%b cnt=%0d data=%h, required 11/1/1/1234",
                  in_ack, err, hs_count, out_data);
      end
      #2 rst_n = 1'b0;
      #1;
      n_tests++;
      if ({out_req, in_ack, out_data, err, hs_count} !== 24'h0) begin
         n_fail++;
         $display("FAIL reset_mid_hold: req=%b ack=%b data=%h err=%b cnt=%0d, required all zero",
                  out_req, in_ack, out_data, err, hs_count);
      end
      idle_inputs();
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
   endtask

   task automatic test_nin1();
      r1_req = 1'b1; r1_data = 8'h5A; tick();
      n_tests++;
      if (r1_out_req !== 1'b1 || r1_out_data !== 8'h5A || r1_in_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL nin1_req: req=%b data=%h ack=%b, required 1/5a/0", r1_out_req, r1_out_data, r1_in_ack);
      end
      r1_out_ack = 1'b1; tick();
      n_tests++;
      if (r1_in_ack !== 1'b1) begin
         n_fail++;
         $display("FAIL nin1_ack: in_ack=%b, required 1", r1_in_ack);
      end
      r1_req = 1'b0; r1_data = 8'hC3; tick();
      n_tests++;
      if (r1_out_req !== 1'b0 || r1_in_ack !== 1'b1 || r1_out_data !== 8'h5A) begin
         n_fail++;
         $display("FAIL nin1_rtz: req=%b ack=%b data=%h, required 0/1/5a", r1_out_req, r1_in_ack, r1_out_data);
      end
      r1_out_ack = 1'b0; tick();
      n_tests++;
      if (r1_hs_count !== 4'd1 || r1_err !== 1'b0 || r1_in_ack !== 1'b0) begin
         n_fail++;
         $display("FAIL nin1_done: cnt=%0d err=%b ack=%b, required 1/0/0", r1_hs_count, r1_err, r1_in_ack);
      end
   endtask

   initial begin
      rst_n = 1'b1;
      idle_inputs();
      test_reset();
      test_partial_join();
      test_handshake();
      test_violation();
      test_data_stability();
      test_wrap();
      test_random();
      test_reset_mid();
      test_nin1();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
